if_fetch_stage: RTL and testbench

- Instruction-fetch stage of the 5-stage RISC-V pipeline.
- Owns the PC register and issues requests to instruction memory over a variable-latency req/ack handshake.
- Loads the IF/ID pipeline register (if_id_reg layout: Curr_Pc in the MSBs, Curr_Instr in the LSBs), honours hazard-unit stall, EX-stage branch flush and WB-stage halt.
- Feeds the decode stage directly.

---
 rtl/if_fetch_stage_if.sv | 25 ++
 rtl/if_fetch_stage.sv | 203 ++++++++++++++++++++
 tb/tb_if_fetch_stage.sv | 294 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/if_fetch_stage_if.sv
// Instruction-memory request/ack bundle between the fetch stage (master) and imem (slave).
// The address must stay stable from request assertion until the matching ack.
interface if_fetch_stage_if #(
    parameter int PC_W    = 9,
    parameter int INSTR_W = 32
);
    logic               imem_req_o;
    logic [PC_W-1:0]    imem_addr_o;
    logic               imem_ack_i;
    logic [INSTR_W-1:0] imem_rdata_i;

    modport master (
        output imem_req_o,
        output imem_addr_o,
        input  imem_ack_i,
        input  imem_rdata_i
    );

    modport slave (
        input  imem_req_o,
        input  imem_addr_o,
        output imem_ack_i,
        output imem_rdata_i
    );
endinterface

// File: rtl/if_fetch_stage.sv
// IF stage: owns PC, fetches over req/ack, loads IF/ID; optional perf counters under IF_PERF_CNT_EN.
// Latency: instruction on if_id_o the cycle after ack; zero-wait memory sustains one per cycle.
// Backpressure: stall holds PC and IF/ID (skid-buffers a late ack); flush redirects; halt is terminal.
module if_fetch_stage #(
    parameter int                PC_W      = 9,
    parameter int                INSTR_W   = 32,
    parameter logic [PC_W-1:0]   RESET_PC  = 9'h000,
    parameter logic [INSTR_W-1:0] NOP_INSTR = 32'h00000013
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     stall_i,
    input  logic                     flush_i,
    input  logic [PC_W-1:0]          branch_tgt_i,
    input  logic                     halt_i,
    if_fetch_stage_if.master         imem,
    output logic [PC_W+INSTR_W-1:0]  if_id_o,
    output logic                     if_id_valid_o,
    output logic [PC_W-1:0]          pc_o,
    output logic                     halted_o,
    output logic [31:0]              fetch_count_o,
    output logic [31:0]              stall_cycles_o
);

    typedef enum logic [1:0] {
        S_FETCH  = 2'd0,
        S_HOLD   = 2'd1,
        S_DRAIN  = 2'd2,
        S_HALTED = 2'd3
    } state_e;

    state_e             state_q, state_d;
    logic [PC_W-1:0]    pc_q, pc_d;
    logic [PC_W-1:0]    drain_addr_q, drain_addr_d;
    logic [INSTR_W-1:0] skid_q, skid_d;
    logic [PC_W-1:0]    cur_pc_q, cur_pc_d;
    logic [INSTR_W-1:0] cur_instr_q, cur_instr_d;
    logic               valid_q, valid_d;
    logic               halted_q, halted_d;
    logic               halt_pend_q, halt_pend_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_FETCH;
            pc_q         <= RESET_PC;
            drain_addr_q <= RESET_PC;
            skid_q       <= NOP_INSTR;
            cur_pc_q     <= RESET_PC;
            cur_instr_q  <= NOP_INSTR;
            valid_q      <= 1'b0;
            halted_q     <= 1'b0;
            halt_pend_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            drain_addr_q <= drain_addr_d;
            skid_q       <= skid_d;
            cur_pc_q     <= cur_pc_d;
            cur_instr_q  <= cur_instr_d;
            valid_q      <= valid_d;
            halted_q     <= halted_d;
            halt_pend_q  <= halt_pend_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        drain_addr_d = drain_addr_q;
        skid_d       = skid_q;
        cur_pc_d     = cur_pc_q;
        cur_instr_d  = cur_instr_q;
        valid_d      = valid_q;
        halted_d     = halted_q;
        halt_pend_d  = halt_pend_q;

        unique case (state_q)
            S_FETCH: begin
                if (halt_i) begin
                    valid_d     = 1'b0;
                    cur_instr_d = NOP_INSTR;
                    halted_d    = 1'b1;
                    if (imem.imem_ack_i) begin
                        state_d = S_HALTED;
                    end else begin
                        state_d      = S_DRAIN;
                        drain_addr_d = pc_q;
                        halt_pend_d  = 1'b1;
                    end
                end else if (flush_i) begin
                    valid_d     = 1'b0;
                    cur_instr_d = NOP_INSTR;
                    pc_d        = branch_tgt_i;
                    // Without an ack the old request is still owed a response; park it in DRAIN.
                    if (!imem.imem_ack_i) begin
                        state_d      = S_DRAIN;
                        drain_addr_d = pc_q;
                    end
                end else if (imem.imem_ack_i) begin
                    if (stall_i) begin
                        skid_d  = imem.imem_rdata_i;
                        state_d = S_HOLD;
                    end else begin
                        cur_pc_d    = pc_q;
                        cur_instr_d = imem.imem_rdata_i;
                        valid_d     = 1'b1;
                        pc_d        = pc_q + PC_W'(4);
                    end
                end else if (!stall_i) begin
                    valid_d     = 1'b0;
                    cur_instr_d = NOP_INSTR;
                end
            end

            S_HOLD: begin
                if (halt_i) begin
                    valid_d     = 1'b0;
                    cur_instr_d = NOP_INSTR;
                    halted_d    = 1'b1;
                    state_d     = S_HALTED;
                end else if (flush_i) begin
                    valid_d     = 1'b0;
                    cur_instr_d = NOP_INSTR;
                    pc_d        = branch_tgt_i;
                    state_d     = S_FETCH;
                end else if (!stall_i) begin
                    cur_pc_d    = pc_q;
                    cur_instr_d = skid_q;
                    valid_d     = 1'b1;
                    pc_d        = pc_q + PC_W'(4);
                    state_d     = S_FETCH;
                end
            end

            S_DRAIN: begin
                // Once a halt is pending the PC is frozen, so later flushes are ignored.
                if (!halt_pend_q) begin
                    if (halt_i) begin
                        valid_d     = 1'b0;
                        cur_instr_d = NOP_INSTR;
                        halted_d    = 1'b1;
                        halt_pend_d = 1'b1;
                    end else if (flush_i) begin
                        valid_d     = 1'b0;
                        cur_instr_d = NOP_INSTR;
                        pc_d        = branch_tgt_i;
                    end
                end
                if (imem.imem_ack_i) begin
                    state_d = halt_pend_d ? S_HALTED : S_FETCH;
                end
            end

            S_HALTED: begin
                state_d = S_HALTED;
            end

            default: begin
                state_d = S_FETCH;
            end
        endcase
    end

    assign imem.imem_req_o  = !reset && ((state_q == S_FETCH) || (state_q == S_DRAIN));
    assign imem.imem_addr_o = (state_q == S_DRAIN) ? drain_addr_q : pc_q;

    assign if_id_o       = {cur_pc_q, cur_instr_q};
    assign if_id_valid_o = valid_q;
    assign pc_o          = pc_q;
    assign halted_o      = halted_q;

`ifdef IF_PERF_CNT_EN
    logic [31:0] fetch_cnt_q, fetch_cnt_d;
    logic [31:0] stall_cnt_q, stall_cnt_d;
    logic        load_vld;

    // Mirrors the two IF/ID load paths: FETCH with ack and HOLD release, neither overridden.
    assign load_vld = !halt_i && !flush_i && !stall_i &&
                      (((state_q == S_FETCH) && imem.imem_ack_i) || (state_q == S_HOLD));

    always_comb begin
        fetch_cnt_d = fetch_cnt_q + (load_vld ? 32'd1 : 32'd0);
        stall_cnt_d = stall_cnt_q + ((stall_i && (state_q != S_HALTED)) ? 32'd1 : 32'd0);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_cnt_q <= 32'd0;
            stall_cnt_q <= 32'd0;
        end else begin
            fetch_cnt_q <= fetch_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign fetch_count_o  = fetch_cnt_q;
    assign stall_cycles_o = stall_cnt_q;
`else
    assign fetch_count_o  = 32'd0;
    assign stall_cycles_o = 32'd0;
`endif

endmodule

// File: tb/tb_if_fetch_stage.sv
// Scoreboarded bench for if_fetch_stage: random-latency imem model plus program-order PC reference.
module tb_if_fetch_stage;
    localparam int          PC_W    = 9;
    localparam int          INSTR_W = 32;
    localparam logic [31:0] NOP     = 32'h00000013;

    logic                    clk = 1'b0;
    logic                    reset;
    logic                    stall_i, flush_i, halt_i;
    logic [PC_W-1:0]         branch_tgt_i;
    logic [PC_W+INSTR_W-1:0] if_id_o;
    logic                    if_id_valid_o;
    logic [PC_W-1:0]         pc_o;
    logic                    halted_o;
    logic [31:0]             fetch_count_o, stall_cycles_o;

    if_fetch_stage_if #(.PC_W(PC_W), .INSTR_W(INSTR_W)) imem ();

    if_fetch_stage dut (
        .clk            (clk),
        .reset          (reset),
        .stall_i        (stall_i),
        .flush_i        (flush_i),
        .branch_tgt_i   (branch_tgt_i),
        .halt_i         (halt_i),
        .imem           (imem.master),
        .if_id_o        (if_id_o),
        .if_id_valid_o  (if_id_valid_o),
        .pc_o           (pc_o),
        .halted_o       (halted_o),
        .fetch_count_o  (fetch_count_o),
        .stall_cycles_o (stall_cycles_o)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    logic [PC_W-1:0] exp_q[$];
    int loads = 0;
    int stall_edges = 0;
    int lat_min = 0, lat_max = 0, mem_lat = 0, mem_cnt = 0;
    logic prev_wait = 1'b0;
    logic [PC_W-1:0] prev_addr = '0;

    function automatic logic [31:0] mem_word(input logic [PC_W-1:0] a);
        return {7'h55, 16'hC0DE, a};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Program order after a redirect: sequential words from the target, wrapping at 2^PC_W.
    task automatic refill(input logic [PC_W-1:0] start);
        logic [PC_W-1:0] a;
        exp_q.delete();
        a = start;
        for (int i = 0; i < 1024; i++) begin
            exp_q.push_back(a);
            a = a + PC_W'(4);
        end
    endtask

    // Instruction memory: answers each request after mem_lat cycles (0 = same cycle).
    initial begin
        imem.imem_ack_i   = 1'b0;
        imem.imem_rdata_i = '0;
        forever begin
            @(negedge clk);
            #1;
            imem.imem_ack_i = 1'b0;
            if (reset) begin
                mem_cnt   = 0;
                prev_wait = 1'b0;
            end else begin
                if (prev_wait) chk("req_held", {63'd0, imem.imem_req_o}, 64'd1);
                if (imem.imem_req_o) begin
                    if (prev_wait) chk("addr_stable", {55'd0, imem.imem_addr_o}, {55'd0, prev_addr});
                    if (mem_cnt >= mem_lat) begin
                        imem.imem_ack_i   = 1'b1;
                        imem.imem_rdata_i = mem_word(imem.imem_addr_o);
                        mem_cnt   = 0;
                        mem_lat   = $urandom_range(lat_max, lat_min);
                        prev_wait = 1'b0;
                    end else begin
                        mem_cnt++;
                        prev_wait = 1'b1;
                        prev_addr = imem.imem_addr_o;
                    end
                end else begin
                    prev_wait = 1'b0;
                end
            end
        end
    end

    // Monitor: a non-stalled edge that leaves IF/ID valid is a new instruction for decode.
    initial begin
        logic st, rs;
        logic [PC_W-1:0] e;
        forever begin
            @(posedge clk);
            st = stall_i;
            rs = reset;
            #1;
            if (rs) begin
                loads = 0;
                stall_edges = 0;
            end else begin
                if (st) stall_edges++;
                if (!st && if_id_valid_o) begin
                    loads++;
                    if (exp_q.size() == 0) begin
                        chk("unexpected_load", {23'd0, if_id_o}, 64'd0);
                    end else begin
                        e = exp_q.pop_front();
                        chk("if_id_pc", {55'd0, if_id_o[40:32]}, {55'd0, e});
                        chk("if_id_instr", {32'd0, if_id_o[31:0]}, {32'd0, mem_word(e)});
                    end
                end
                if (!if_id_valid_o) chk("bubble_nop", {32'd0, if_id_o[31:0]}, {32'd0, NOP});
            end
        end
    end

    task automatic check_perf(input string tag);
`ifdef IF_PERF_CNT_EN
        chk({tag, "_fetch_cnt"}, {32'd0, fetch_count_o}, 64'(loads));
        chk({tag, "_stall_cnt"}, {32'd0, stall_cycles_o}, 64'(stall_edges));
`else
        chk({tag, "_fetch_cnt"}, {32'd0, fetch_count_o}, 64'd0);
        chk({tag, "_stall_cnt"}, {32'd0, stall_cycles_o}, 64'd0);
`endif
    endtask

    task automatic set_lat(input int lo, input int hi);
        lat_min = lo;
        lat_max = hi;
        mem_lat = lo;
        mem_cnt = 0;
    endtask

    initial begin
        int  n;
        int  r;
        logic saw;
        logic [PC_W-1:0] pc_at_halt;

        reset = 1'b1; stall_i = 1'b0; flush_i = 1'b0; halt_i = 1'b0; branch_tgt_i = '0;
        set_lat(0, 0);
        repeat (3) @(negedge clk);
        chk("rst_req", {63'd0, imem.imem_req_o}, 64'd0);
        chk("rst_valid", {63'd0, if_id_valid_o}, 64'd0);
        chk("rst_if_id", {23'd0, if_id_o}, {23'd0, 9'h000, NOP});
        chk("rst_pc", {55'd0, pc_o}, 64'd0);
        chk("rst_halted", {63'd0, halted_o}, 64'd0);
        check_perf("rst");

        // Zero-wait memory: one instruction per cycle.
        refill(9'h000);
        reset = 1'b0;
        @(posedge clk); #1;
        chk("first_load", {23'd0, if_id_o}, {23'd0, 9'h000, mem_word(9'h000)});
        chk("first_valid", {63'd0, if_id_valid_o}, 64'd1);
        repeat (6) @(negedge clk);

        // Stall while the ack for 0x010 arrives.
        flush_i = 1'b1; branch_tgt_i = 9'h000; refill(9'h000);
        @(negedge clk);
        flush_i = 1'b0;
        n = 0;
        while (pc_o != 9'h010 && n < 50) begin @(negedge clk); n++; end
        chk("wait_pc10", 64'(n < 50), 64'd1);
        stall_i = 1'b1;
        @(negedge clk);
        chk("hold_req", {63'd0, imem.imem_req_o}, 64'd0);
        chk("hold_ifid_pc", {55'd0, if_id_o[40:32]}, 64'h00C);
        chk("hold_valid", {63'd0, if_id_valid_o}, 64'd1);
        chk("hold_pc", {55'd0, pc_o}, 64'h010);
        repeat (2) @(negedge clk);
        stall_i = 1'b0;
        @(negedge clk);
        chk("unstall_ifid_pc", {55'd0, if_id_o[40:32]}, 64'h010);
        chk("unstall_pc", {55'd0, pc_o}, 64'h014);

        // Latency 3: flush + stall against an outstanding request for 0x020.
        set_lat(3, 3);
        n = 0;
        while (!(imem.imem_req_o && imem.imem_addr_o == 9'h020 && mem_cnt == 0) && n < 100) begin
            @(negedge clk); n++;
        end
        chk("wait_req20", 64'(n < 100), 64'd1);
        flush_i = 1'b1; stall_i = 1'b1; branch_tgt_i = 9'h080; refill(9'h080);
        @(negedge clk);
        flush_i = 1'b0; stall_i = 1'b0;
        chk("drain_req", {63'd0, imem.imem_req_o}, 64'd1);
        chk("drain_addr", {55'd0, imem.imem_addr_o}, 64'h020);
        chk("drain_pc", {55'd0, pc_o}, 64'h080);
        chk("drain_valid", {63'd0, if_id_valid_o}, 64'd0);
        n = 0;
        while (!(imem.imem_req_o && imem.imem_addr_o == 9'h080) && n < 20) begin @(negedge clk); n++; end
        chk("redirect_addr", 64'(n < 20), 64'd1);

        // Latency 2: bubbles between instructions.
        set_lat(2, 2);
        saw = 1'b0;
        repeat (16) begin
            @(negedge clk);
            if (!if_id_valid_o) saw = 1'b1;
        end
        chk("lat2_bubble", {63'd0, saw}, 64'd1);

        // PC wrap at the top of the address space.
        set_lat(0, 0);
        @(negedge clk);
        n = 0;
        while (imem.imem_req_o !== 1'b1 && n < 10) begin @(negedge clk); n++; end
        flush_i = 1'b1; branch_tgt_i = 9'h1F8; refill(9'h1F8);
        @(negedge clk);
        flush_i = 1'b0;
        repeat (2) @(negedge clk);
        chk("wrap_pc", {55'd0, pc_o}, 64'h000);
        chk("wrap_ifid_pc", {55'd0, if_id_o[40:32]}, 64'h1FC);

        // Random stall/flush traffic with random memory latency.
        set_lat(0, 3);
        for (int i = 0; i < 800; i++) begin
            stall_i = ($urandom_range(3, 0) == 0);
            if ($urandom_range(19, 0) == 0) begin
                r = $urandom_range(127, 0);
                flush_i = 1'b1;
                branch_tgt_i = 9'(r * 4);
                refill(branch_tgt_i);
            end else begin
                flush_i = 1'b0;
            end
            @(negedge clk);
        end
        stall_i = 1'b0; flush_i = 1'b0;
        @(negedge clk);
        check_perf("run");

        // Halt with a request outstanding.
        set_lat(4, 4);
        n = 0;
        while (!(imem.imem_req_o && mem_cnt < mem_lat) && n < 50) begin @(negedge clk); n++; end
        chk("wait_halt_req", 64'(n < 50), 64'd1);
        pc_at_halt = pc_o;
        halt_i = 1'b1;
        exp_q.delete();
        @(negedge clk);
        halt_i = 1'b0;
        chk("halt_flag", {63'd0, halted_o}, 64'd1);
        chk("halt_req_held", {63'd0, imem.imem_req_o}, 64'd1);
        chk("halt_valid", {63'd0, if_id_valid_o}, 64'd0);
        n = 0;
        while (imem.imem_req_o && n < 10) begin @(negedge clk); n++; end
        chk("halt_req_drop", 64'(n < 10), 64'd1);
        for (int i = 0; i < 10; i++) begin
            stall_i = i[0];
            @(negedge clk);
            chk("halted_req", {63'd0, imem.imem_req_o}, 64'd0);
        end
        stall_i = 1'b0;
        chk("halted_flag", {63'd0, halted_o}, 64'd1);
        chk("halted_pc", {55'd0, pc_o}, {55'd0, pc_at_halt});

        // Reset restarts fetch at RESET_PC.
        set_lat(0, 0);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        refill(9'h000);
        reset = 1'b0;
        @(posedge clk); #1;
        chk("restart_load", {23'd0, if_id_o}, {23'd0, 9'h000, mem_word(9'h000)});
        chk("restart_halted", {63'd0, halted_o}, 64'd0);
        repeat (5) @(negedge clk);
        check_perf("restart");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end
endmodule
